// File: rtl/hello_rx_pkg.sv
// hello_rx_pkg
//   Shared definitions for the hello message generator / receiver pair:
//   receiver state encodings and the default message, so both ends of a
//   link built from these blocks agree on what is being sent.
package hello_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  // Default message; the leftmost character is the first byte on the wire.
  localparam int          HELLO_MSG_LEN = 5;
  localparam logic [39:0] HELLO_MSG     = "hello";

endpackage

// File: rtl/hello_sat_cnt.sv
// hello_sat_cnt
//   Saturating up-counter: increments on inc and holds at all-ones.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset (clears q)
//     inc   - increment request for this cycle
//     q     - current count
module hello_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hello_rx.sv
// hello_rx
//   Receive-side checker for the repeating hello message stream. Hunts for
//   the first message byte, verifies LOCK_COUNT consecutive clean messages,
//   then flywheels on the message boundary, tolerating up to MISS_LIMIT-1
//   consecutive bad messages before dropping back to hunting.
//   Ports:
//     clk       - clock, rising edge
//     rst_n     - asynchronous active-low reset
//     in_valid  - in_data carries a stream byte this cycle
//     in_data   - stream byte
//     locked    - aligned to the message boundary
//     msg_pulse - one-cycle strobe per clean message while locked
//     msg_count - clean messages while locked (saturating)
//     err_count - mismatched bytes while locked (saturating)
//     state     - debug state (0 HUNT, 1 VERIFY, 2 LOCKED)
module hello_rx
  import hello_rx_pkg::*;
#(
  parameter int                   MSG_LEN    = HELLO_MSG_LEN,
  parameter logic [8*MSG_LEN-1:0] MSG        = HELLO_MSG,
  parameter int                   LOCK_COUNT = 2,
  parameter int                   MISS_LIMIT = 3,
  parameter int                   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             msg_pulse,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam int GR_W  = $clog2(LOCK_COUNT + 1);
  localparam int MS_W  = $clog2(MISS_LIMIT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MSG_LEN - 1);
  localparam logic [7:0]       FIRST_BYTE = MSG[8*MSG_LEN-1 -: 8];

  // Message unpacked into a byte table sized to the full index range so the
  // lookup never needs a bounds check; unused slots are never addressed.
  logic [7:0] w_msg_bytes [2**IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2**IDX_W; gi++) begin : g_msg
      if (gi < MSG_LEN) begin : g_used
        assign w_msg_bytes[gi] = MSG[8*(MSG_LEN-gi)-1 -: 8];
      end else begin : g_unused
        assign w_msg_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  rx_state_t        r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [GR_W-1:0]  r_good_run, w_good_next;
  logic [MS_W-1:0]  r_miss, w_miss_next;
  logic             r_bad, w_bad_next;
  logic             r_msg_pulse, w_pulse_next;
  logic             w_msg_inc, w_err_inc;
  logic             w_match, w_last, w_is_first;

  assign w_match    = (in_data == w_msg_bytes[r_idx]);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_is_first = (in_data == FIRST_BYTE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HUNT;
      r_idx       <= '0;
      r_good_run  <= '0;
      r_miss      <= '0;
      r_bad       <= 1'b0;
      r_msg_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_good_run  <= w_good_next;
      r_miss      <= w_miss_next;
      r_bad       <= w_bad_next;
      r_msg_pulse <= w_pulse_next;
    end
  end

  // Next-state logic; idle cycles hold everything except the strobe.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_good_next  = r_good_run;
    w_miss_next  = r_miss;
    w_bad_next   = r_bad;
    w_pulse_next = 1'b0;
    w_msg_inc    = 1'b0;
    w_err_inc    = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_is_first) begin
            w_state_next = ST_VERIFY;
            w_idx_next   = IDX_W'(1);
            w_good_next  = '0;
          end
        end
        ST_VERIFY: begin
          if (w_match) begin
            if (w_last) begin
              w_idx_next  = '0;
              w_good_next = r_good_run + GR_W'(1);
              if (r_good_run == GR_W'(LOCK_COUNT - 1)) begin
                w_state_next = ST_LOCKED;
                w_good_next  = '0;
                w_miss_next  = '0;
                w_bad_next   = 1'b0;
              end
            end else begin
              w_idx_next = r_idx + IDX_W'(1);
            end
          end else begin
            w_good_next = '0;
            // A stray first byte may itself start the real message.
            if (w_is_first) begin
              w_idx_next = IDX_W'(1);
            end else begin
              w_state_next = ST_HUNT;
              w_idx_next   = '0;
            end
          end
        end
        ST_LOCKED: begin
          // Flywheel: the boundary is trusted, so idx advances regardless.
          w_idx_next = w_last ? '0 : r_idx + IDX_W'(1);
          if (!w_match) begin
            w_err_inc  = 1'b1;
            w_bad_next = 1'b1;
          end
          if (w_last) begin
            w_bad_next = 1'b0;
            if (!r_bad && w_match) begin
              w_pulse_next = 1'b1;
              w_msg_inc    = 1'b1;
              w_miss_next  = '0;
            end else if (r_miss == MS_W'(MISS_LIMIT - 1)) begin
              w_state_next = ST_HUNT;
              w_idx_next   = '0;
              w_miss_next  = '0;
            end else begin
              w_miss_next = r_miss + MS_W'(1);
            end
          end
        end
        default: begin
          w_state_next = ST_HUNT;
          w_idx_next   = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    locked    = (r_state == ST_LOCKED);
    state     = r_state;
    msg_pulse = r_msg_pulse;
  end

  hello_sat_cnt #(.W(CNT_W)) u_msg_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_msg_inc),
    .q     (msg_count)
  );

  hello_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_err_inc),
    .q     (err_count)
  );

endmodule
